ami_w: RTL
==========

AMI_W -- requirements
Module: ami_w

Interface
REQ-001 Params: AXI_DW 128 (data width); AXI_AW 32 (address width); AXI_IW 8 (ID width); AXI_LW 8 (AWLEN width); AXI_SW 3 (AWSIZE width); AXI_BRESPW 2 (BRESP width); AMI_OD 4 (max outstanding bursts, power of 2).
REQ-002 ACLK  in  1  single clock, all logic on rising edge.
REQ-003 ARESETn  in  1  asynchronous, active-low reset.
REQ-004 usr_cmd_valid/usr_cmd_ready  in/out  1/1  user burst command handshake.
REQ-005 usr_cmd_id/addr/len/size/burst  in  AXI_IW/AXI_AW/AXI_LW/AXI_SW/2  command fields.
REQ-006 usr_wdata/usr_wstrb/usr_wvalid/usr_wready  in/in/in/out  AXI_DW/AXI_DW/8/1/1  user write-data stream.
REQ-007 usr_bid/usr_bresp/usr_bvalid/usr_bready  out/out/out/in  AXI_IW/AXI_BRESPW/1/1  response to user.
REQ-008 usr_cmd_err  out  1  one-cycle pulse, command dropped (see REQ-024).
REQ-009 usr_busy  out  1  outstanding burst count nonzero.
REQ-010 AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID out, AWREADY in; WDATA/WSTRB/WLAST/WVALID out, WREADY in; BID/BRESP/BVALID in, BREADY out; AXI4 widths per params.

Function
REQ-011 usr_cmd_ready = !AWVALID && os_cnt<AMI_OD && length queue not full.
REQ-012 Command accept (valid&&ready) loads AW fields into registers; AWVALID asserts the next cycle (latency 1) and holds, fields stable, until AWVALID&&AWREADY.
REQ-013 Same accept pushes cmd_len into length queue (depth AMI_OD) and increments os_cnt.
REQ-014 W channel is gated by queue non-empty: WVALID = usr_wvalid && !lq_empty; usr_wready = WREADY && !lq_empty; WDATA/WSTRB pass through combinationally.
REQ-015 W-side state machine: W_IDLE (queue empty) -> W_DATA (head present); W_DATA -> W_IDLE on WLAST handshake with queue becoming empty, else stays W_DATA for next burst.
REQ-016 beat_cnt (AXI_LW bits) increments on each W handshake; WLAST = (beat_cnt == queue head); on WLAST handshake beat_cnt clears to 0 and queue pops.
REQ-017 W beats may complete before the matching AW handshake; no ordering dependency between AW and W.
REQ-018 len==0: single beat, WLAST on first beat; len==2^AXI_LW-1 counts without overflow.
REQ-019 B pass-through: usr_bvalid=BVALID, BREADY=usr_bready, usr_bid=BID, usr_bresp=BRESP.
REQ-020 os_cnt (clog2(AMI_OD+1) bits) decrements on B handshake; simultaneous accept and B handshake leaves it unchanged; never exceeds AMI_OD or underflows.
REQ-021 usr_busy = (os_cnt != 0).

Reset
REQ-022 While ARESETn low: AWVALID 0, AW field registers 0, os_cnt 0, beat_cnt 0, queue empty, usr_cmd_err 0; hence WVALID 0, usr_wready 0, usr_cmd_ready 1.
REQ-023 Reset mid-burst abandons all in-flight state; first post-reset command behaves as from idle.

Configuration
REQ-024 Macro AMI_W_4KB_CHECK_EN defined: an INCR/WRAP command whose last byte ((addr aligned to size)+((len+1)<<size)-1) differs from addr in bits [AXI_AW-1:12] is accepted (usr_cmd_ready honoured), pulses usr_cmd_err next cycle, issues no AW, pushes no length, leaves os_cnt unchanged; FIXED never flagged; check absent when AXI_AW<=12.
REQ-025 Macro undefined: usr_cmd_err tied 0; all commands issued unchanged.

Structure
REQ-026 Burst-type constants (FIXED 0, INCR 1, WRAP 2) and 4 KB boundary constant live in shared package axi_pkg.
REQ-027 Length queue is one sub-module instance: synchronous FIFO sfifo (parameters AW=clog2(AMI_OD), DW=AXI_LW).

Verification
REQ-028 Cmd addr 0x1000 len 3 size 4 INCR, AWREADY=1, WREADY=1 -> AWVALID one cycle after accept; 4 W beats, WLAST only on 4th; BVALID with BRESP 0 -> usr_bresp 0, usr_busy falls.
REQ-029 Issue 5 cmds len 0 with BVALID held 0 (AMI_OD 4) -> usr_cmd_ready low after 4th; first B handshake re-enables it.
REQ-030 WREADY held 1, AWREADY held 0 for 10 cycles -> all W beats of the burst complete, AWVALID/AWADDR stable until AWREADY.
REQ-031 Accept and B handshake same cycle with os_cnt 2 -> os_cnt stays 2.
REQ-032 With AMI_W_4KB_CHECK_EN: addr 0x0FF0 len 1 size 4 INCR -> usr_cmd_err pulse, no AWVALID, os_cnt unchanged; without macro -> AW issued at 0x0FF0.
REQ-033 Assert ARESETn low mid-burst (beat 2 of 8) -> AWVALID/WVALID 0, usr_busy 0; new len 0 cmd after release completes normally.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI constants: burst-type encodings, the 4 KB boundary, and the W-side state type.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam int unsigned BOUNDARY_4KB     = 4096;
  localparam int unsigned BOUNDARY_4KB_LSB = $clog2(BOUNDARY_4KB);

  typedef enum logic {
    W_IDLE = 1'b0,
    W_DATA = 1'b1
  } w_state_t;

endpackage

// File: rtl/sfifo.sv
// Synchronous FIFO with a combinational head read; depth is 2**AW entries of DW bits.
module sfifo #(
  parameter int AW = 2,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [AW:0]   count_o
);

  localparam int         DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          push_ok_s, pop_ok_s;

  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == DEPTH_C);
  assign count_o   = cnt_q;
  assign rdata_o   = mem_q[rptr_q];
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok_s) wptr_q <= wptr_q + AW'(1);
      if (pop_ok_s)  rptr_q <= rptr_q + AW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/ami_w.sv
// AXI4 write master: user burst commands to AW, length-tracked W stream, B pass-through.
// Optional 4 KB crossing rejection is enabled by defining AMI_W_4KB_CHECK_EN.
module ami_w
  import axi_pkg::*;
#(
  parameter int AXI_DW     = 128,
  parameter int AXI_AW     = 32,
  parameter int AXI_IW     = 8,
  parameter int AXI_LW     = 8,
  parameter int AXI_SW     = 3,
  parameter int AXI_BRESPW = 2,
  parameter int AMI_OD     = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  usr_cmd_valid,
  output logic                  usr_cmd_ready,
  input  logic [AXI_IW-1:0]     usr_cmd_id,
  input  logic [AXI_AW-1:0]     usr_cmd_addr,
  input  logic [AXI_LW-1:0]     usr_cmd_len,
  input  logic [AXI_SW-1:0]     usr_cmd_size,
  input  logic [1:0]            usr_cmd_burst,
  input  logic [AXI_DW-1:0]     usr_wdata,
  input  logic [AXI_DW/8-1:0]   usr_wstrb,
  input  logic                  usr_wvalid,
  output logic                  usr_wready,
  output logic [AXI_IW-1:0]     usr_bid,
  output logic [AXI_BRESPW-1:0] usr_bresp,
  output logic                  usr_bvalid,
  input  logic                  usr_bready,
  output logic                  usr_cmd_err,
  output logic                  usr_busy,
  output logic [AXI_IW-1:0]     AWID,
  output logic [AXI_AW-1:0]     AWADDR,
  output logic [AXI_LW-1:0]     AWLEN,
  output logic [AXI_SW-1:0]     AWSIZE,
  output logic [1:0]            AWBURST,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [AXI_DW-1:0]     WDATA,
  output logic [AXI_DW/8-1:0]   WSTRB,
  output logic                  WLAST,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [AXI_IW-1:0]     BID,
  input  logic [AXI_BRESPW-1:0] BRESP,
  input  logic                  BVALID,
  output logic                  BREADY
);

  localparam int             LQ_AW = $clog2(AMI_OD);
  localparam int             OSW   = $clog2(AMI_OD + 1);
  localparam logic [OSW-1:0] OD_C  = OSW'(AMI_OD);

  logic [OSW-1:0]    os_cnt_q, os_cnt_d;
  logic [AXI_LW-1:0] beat_cnt_q;
  w_state_t          w_state_q;
  logic              err_q;
  logic [AXI_LW-1:0] lq_head_s;
  logic              lq_empty_s, lq_full_s;
  logic [LQ_AW:0]    lq_count_s;
  logic              cmd_accept_s, issue_s, cross_4kb_s;
  logic              aw_hs_s, w_hs_s, b_hs_s, os_dec_s;

`ifdef AMI_W_4KB_CHECK_EN
  if (AXI_AW > int'(BOUNDARY_4KB_LSB)) begin : g_4kb
    logic [AXI_AW-1:0] start_s, last_s;
    assign start_s     = usr_cmd_addr & ~((AXI_AW'(1) << usr_cmd_size) - AXI_AW'(1));
    assign last_s      = start_s + ((AXI_AW'(usr_cmd_len) + AXI_AW'(1)) << usr_cmd_size) - AXI_AW'(1);
    assign cross_4kb_s = ((usr_cmd_burst == BURST_INCR) || (usr_cmd_burst == BURST_WRAP)) &&
                         (last_s[AXI_AW-1:BOUNDARY_4KB_LSB] != usr_cmd_addr[AXI_AW-1:BOUNDARY_4KB_LSB]);
  end else begin : g_no4kb
    assign cross_4kb_s = 1'b0;
  end
`else
  assign cross_4kb_s = 1'b0;
`endif

  assign usr_cmd_ready = !AWVALID && (os_cnt_q < OD_C) && !lq_full_s;
  assign cmd_accept_s  = usr_cmd_valid && usr_cmd_ready;
  assign issue_s       = cmd_accept_s && !cross_4kb_s;
  assign aw_hs_s       = AWVALID && AWREADY;
  assign b_hs_s        = BVALID && usr_bready;
  assign os_dec_s      = b_hs_s && (os_cnt_q != '0);

  // W is held off until a burst length is known; AW ordering is irrelevant.
  assign WVALID     = usr_wvalid && !lq_empty_s;
  assign usr_wready = WREADY && !lq_empty_s;
  assign WDATA      = usr_wdata;
  assign WSTRB      = usr_wstrb;
  assign WLAST      = !lq_empty_s && (beat_cnt_q == lq_head_s);
  assign w_hs_s     = WVALID && WREADY;

  assign usr_bvalid  = BVALID;
  assign usr_bid     = BID;
  assign usr_bresp   = BRESP;
  assign BREADY      = usr_bready;
  assign usr_busy    = (os_cnt_q != '0);
  assign usr_cmd_err = err_q;

  sfifo #(.AW(LQ_AW), .DW(AXI_LW)) u_len_q (
    .clk_i   (ACLK),
    .rst_ni  (ARESETn),
    .push_i  (issue_s),
    .wdata_i (usr_cmd_len),
    .pop_i   (w_hs_s && WLAST),
    .rdata_o (lq_head_s),
    .empty_o (lq_empty_s),
    .full_o  (lq_full_s),
    .count_o (lq_count_s)
  );

  always_comb begin
    os_cnt_d = os_cnt_q;
    case ({issue_s, os_dec_s})
      2'b10:   os_cnt_d = os_cnt_q + OSW'(1);
      2'b01:   os_cnt_d = os_cnt_q - OSW'(1);
      default: os_cnt_d = os_cnt_q;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      AWVALID  <= 1'b0;
      AWID     <= '0;
      AWADDR   <= '0;
      AWLEN    <= '0;
      AWSIZE   <= '0;
      AWBURST  <= '0;
      err_q    <= 1'b0;
      os_cnt_q <= '0;
    end else begin
      if (issue_s) begin
        AWVALID <= 1'b1;
        AWID    <= usr_cmd_id;
        AWADDR  <= usr_cmd_addr;
        AWLEN   <= usr_cmd_len;
        AWSIZE  <= usr_cmd_size;
        AWBURST <= usr_cmd_burst;
      end else if (aw_hs_s) begin
        AWVALID <= 1'b0;
      end
      err_q    <= cmd_accept_s && cross_4kb_s;
      os_cnt_q <= os_cnt_d;
    end
  end

  // Beats can be taken the cycle after a push while the state still reads idle.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_q  <= W_IDLE;
      beat_cnt_q <= '0;
    end else begin
      if (w_hs_s) begin
        beat_cnt_q <= WLAST ? '0 : beat_cnt_q + AXI_LW'(1);
      end
      case (w_state_q)
        W_IDLE: begin
          if (!lq_empty_s) w_state_q <= W_DATA;
        end
        W_DATA: begin
          if (w_hs_s && WLAST && (lq_count_s == (LQ_AW+1)'(1)) && !issue_s) w_state_q <= W_IDLE;
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

endmodule
